// File: rtl/conv1_maxpool.sv
// Purpose : 1-D max-pool (window = stride = POOL) over a LEN-sample conv1 output frame, one channel.
// Latency : pooled sample is registered 1 cycle after the window's last ivalid; frame_done on the same edge as the frame's last ivalid.
// Backpressure: none; the upstream stream is push-only, and each ivalid in RUN is consumed the cycle it arrives.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        asynchronous reset, active low
//   start      arms a new frame (sampled in IDLE only)
//   idata      signed 16-bit conv1 sample, qualified by ivalid
//   ivalid     one-cycle strobe per input sample; gaps allowed
//   odata      signed pooled maximum, holds between pulses
//   ovalid     one-cycle pulse per completed window
//   busy       high while a frame is being consumed (RUN)
//   frame_done one-cycle pulse at end of frame (DONE)

module conv1_maxpool #(
    parameter int LEN  = 128,
    parameter int POOL = 2,
    parameter int CW   = $clog2(LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] idata,
    input  logic               ivalid,
    output logic signed [15:0] odata,
    output logic               ovalid,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_IN  = CW'(LEN - 1);
    localparam logic [CW-1:0] LAST_WIN = CW'(POOL - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CW-1:0]      r_in_cnt;
    logic [CW-1:0]      r_win_cnt;
    logic signed [15:0] r_max;
    logic signed [15:0] r_odata;
    logic               r_ovalid;
    logic               r_frame_done;

    logic               w_sample;
    logic               w_win_first;
    logic               w_win_last;
    logic               w_frame_last;
    logic signed [15:0] w_max;

    // Only samples that arrive while running count toward window/frame alignment.
    assign w_sample     = (r_state == S_RUN) && ivalid;
    assign w_win_first  = (r_win_cnt == '0);
    assign w_win_last   = (r_win_cnt == LAST_WIN);
    assign w_frame_last = (r_in_cnt == LAST_IN);

    // Running maximum including the current sample. The first sample of a
    // window seeds the max so nothing leaks across window boundaries.
    // Strict '>' keeps the stored value on ties.
    always_comb begin
        w_max = r_max;
        if (w_win_first) begin
            w_max = idata;
        end else if (idata > r_max) begin
            w_max = idata;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_sample && w_frame_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_cnt     <= '0;
            r_win_cnt    <= '0;
            r_max        <= '0;
            r_odata      <= '0;
            r_ovalid     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Pulses default low every cycle; odata deliberately holds.
            r_ovalid     <= 1'b0;
            r_frame_done <= 1'b0;

            if ((r_state == S_IDLE) && start) begin
                r_in_cnt  <= '0;
                r_win_cnt <= '0;
                r_max     <= '0;
            end

            if (w_sample) begin
                r_max    <= w_max;
                r_in_cnt <= r_in_cnt + CW'(1);

                if (w_win_last) begin
                    r_win_cnt <= '0;
                    r_odata   <= w_max;
                    r_ovalid  <= 1'b1;
                end else begin
                    r_win_cnt <= r_win_cnt + CW'(1);
                end

                // Raised on the edge that enters DONE, so it is high for
                // exactly the DONE cycle. A trailing partial window simply
                // never reaches w_win_last and produces no ovalid.
                if (w_frame_last) begin
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    assign odata      = r_odata;
    assign ovalid     = r_ovalid;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == S_RUN);

endmodule

// File: tb/tb_conv1_maxpool.sv
module tb_conv1_maxpool;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [15:0] idata;
    logic               ivalid;

    // Three instances share one stimulus bus; each test checks the one
    // whose LEN matches the scenario. Reset between tests realigns them.
    logic signed [15:0] od8, od4, od5;
    logic               ov8, ov4, ov5;
    logic               bz8, bz4, bz5;
    logic               fd8, fd4, fd5;

    int n_checks = 0;
    int n_errors = 0;

    conv1_maxpool #(.LEN(8), .POOL(2)) u8 (
        .clk(clk), .rst(rst), .start(start), .idata(idata), .ivalid(ivalid),
        .odata(od8), .ovalid(ov8), .busy(bz8), .frame_done(fd8)
    );

    conv1_maxpool #(.LEN(4), .POOL(2)) u4 (
        .clk(clk), .rst(rst), .start(start), .idata(idata), .ivalid(ivalid),
        .odata(od4), .ovalid(ov4), .busy(bz4), .frame_done(fd4)
    );

    conv1_maxpool #(.LEN(5), .POOL(2)) u5 (
        .clk(clk), .rst(rst), .start(start), .idata(idata), .ivalid(ivalid),
        .odata(od5), .ovalid(ov5), .busy(bz5), .frame_done(fd5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs of that edge are visible afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] d);
        idata  = d;
        ivalid = 1'b1;
        tick();
        ivalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic signed [15:0] in8  [8] = '{16'sd3, 16'sd7, 16'sd5, 16'sd1, 16'sd0, 16'sd0, 16'sd9, 16'sd9};
    logic signed [15:0] exp8 [4] = '{16'sd7, 16'sd5, 16'sd0, 16'sd9};
    logic signed [15:0] in5  [5] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd6};

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        idata  = '0;
        ivalid = 1'b0;

        // ---- reset state and idle behaviour ----
        tick();
        check("rst_od8", od8, 16'h0000);
        check("rst_ov8", {15'b0, ov8}, 16'h0000);
        check("rst_bz8", {15'b0, bz8}, 16'h0000);
        check("rst_fd8", {15'b0, fd8}, 16'h0000);
        check("rst_od4", od4, 16'h0000);
        check("rst_od5", od5, 16'h0000);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            send(16'sd100 + 16'(i));
            check("idle_ov", {15'b0, ov8}, 16'h0000);
            check("idle_fd", {15'b0, fd8}, 16'h0000);
            check("idle_bz", {15'b0, bz8}, 16'h0000);
            check("idle_od", od8, 16'h0000);
        end

        // ---- basic frame, LEN=8 ----
        do_reset();
        pulse_start();
        check("basic_busy0", {15'b0, bz8}, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            send(in8[i]);
            if (i % 2 == 1) begin
                check("basic_ov", {15'b0, ov8}, 16'h0001);
                check("basic_od", od8, exp8[i/2]);
            end else begin
                check("basic_ov0", {15'b0, ov8}, 16'h0000);
            end
            check("basic_fd", {15'b0, fd8}, (i == 7) ? 16'h0001 : 16'h0000);
            check("basic_bz", {15'b0, bz8}, (i == 7) ? 16'h0000 : 16'h0001);
        end
        tick();
        check("basic_fd_end", {15'b0, fd8}, 16'h0000);
        check("basic_ov_end", {15'b0, ov8}, 16'h0000);
        check("basic_od_hold", od8, 16'h0009);

        // ---- signed values with a gap, LEN=4 ----
        do_reset();
        pulse_start();
        send(-16'sd5);
        check("sgn_ov_a", {15'b0, ov4}, 16'h0000);
        send(-16'sd2);
        check("sgn_ov_b", {15'b0, ov4}, 16'h0001);
        check("sgn_od_b", od4, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_ov", {15'b0, ov4}, 16'h0000);
            check("gap_bz", {15'b0, bz4}, 16'h0001);
        end
        send(-16'sd1);
        check("sgn_ov_c", {15'b0, ov4}, 16'h0000);
        send(-16'sd8);
        check("sgn_ov_d", {15'b0, ov4}, 16'h0001);
        check("sgn_od_d", od4, 16'hFFFF);
        check("sgn_fd", {15'b0, fd4}, 16'h0001);

        // ---- partial tail, LEN=5 ----
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send(in5[i]);
            if (i == 1) begin
                check("tail_ov1", {15'b0, ov5}, 16'h0001);
                check("tail_od1", od5, 16'h0002);
            end else if (i == 3) begin
                check("tail_ov3", {15'b0, ov5}, 16'h0001);
                check("tail_od3", od5, 16'h0004);
            end else begin
                check("tail_ov0", {15'b0, ov5}, 16'h0000);
            end
            check("tail_fd", {15'b0, fd5}, (i == 4) ? 16'h0001 : 16'h0000);
        end
        check("tail_od_hold", od5, 16'h0004);

        // ---- start ignored mid-RUN, async reset, clean restart (LEN=4) ----
        do_reset();
        pulse_start();
        send(16'sd100);
        check("mid_ov_a", {15'b0, ov4}, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_bz", {15'b0, bz4}, 16'h0001);
        send(16'sd50);
        check("mid_ov_b", {15'b0, ov4}, 16'h0001);
        check("mid_od_b", od4, 16'h0064);
        send(16'sd30);
        check("mid_ov_c", {15'b0, ov4}, 16'h0000);
        #2;
        rst = 1'b0;
        #1;
        check("arst_od", od4, 16'h0000);
        check("arst_bz", {15'b0, bz4}, 16'h0000);
        check("arst_ov", {15'b0, ov4}, 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        pulse_start();
        send(16'sd8);
        check("re_ov_a", {15'b0, ov4}, 16'h0000);
        send(16'sd8);
        check("re_ov_b", {15'b0, ov4}, 16'h0001);
        check("re_od_b", od4, 16'h0008);
        send(16'sd2);
        check("re_ov_c", {15'b0, ov4}, 16'h0000);
        send(16'sd4);
        check("re_ov_d", {15'b0, ov4}, 16'h0001);
        check("re_od_d", od4, 16'h0004);
        check("re_fd", {15'b0, fd4}, 16'h0001);
        tick();
        check("re_fd_end", {15'b0, fd4}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/conv1_maxpool.md
Name: conv1_maxpool

Overview:
- Downstream neighbour of the conv1 processing element. Consumes its quantized, ReLU'd 16-bit output stream for one channel.
- Performs 1-D max-pooling with a kernel and stride of POOL samples over a frame of LEN samples.
- Emits one pooled sample per completed window and a single-cycle frame-complete strobe.
- Output feeds the next conv layer's input buffer.

Parameters:
- LEN, 128, number of conv1 output samples per frame (per channel); must be ≥ POOL.
- POOL, 2, pooling window size and stride; must be ≥ 2.
- CW, $clog2(LEN+1), width of the internal sample and window counters (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  arms a new frame; sampled in IDLE only.
- idata  input  16  signed conv1 result sample.
- ivalid  input  1  idata valid this cycle; one-cycle strobe per sample, may arrive back-to-back or with gaps.
- odata  output  16  signed pooled maximum.
- ovalid  output  1  odata valid; one-cycle pulse per pooled sample.
- busy  output  1  high while in RUN.
- frame_done  output  1  one-cycle pulse marking end of frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: odata=0, ovalid=0, busy=0, frame_done=0.
  - Internals: state=IDLE, in_cnt=0, win_cnt=0, max_reg=0.
  - Reset mid-frame abandons the frame with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ivalid is ignored.
  - start=1 → RUN; clears in_cnt, win_cnt and max_reg.
- RUN (busy=1):
  - start is ignored.
  - On each ivalid:
    - win_cnt==0: max_reg<=idata.
    - Otherwise: max_reg<=max(max_reg, idata), signed compare.
    - win_cnt increments; in_cnt increments.
  - Window close (ivalid with win_cnt==POOL-1):
    - odata<=max(max_reg, idata) and ovalid<=1 on the same edge, i.e. 1-cycle latency from the window's last ivalid.
    - win_cnt<=0.
  - Frame end (ivalid with in_cnt==LEN-1): state→DONE on that edge.
  - Tail: if LEN is not a multiple of POOL, the trailing partial window is discarded (no ovalid for it).
- DONE:
  - frame_done=1 and busy=0 for exactly one cycle, coinciding with the final window's ovalid when that window is complete.
  - ivalid and start are ignored.
  - Next state is IDLE unconditionally.
- Outputs: ovalid and frame_done are registered pulses, deasserted every cycle they are not set.
- odata holds its last value between pulses.
- Pooled samples per frame: floor(LEN/POOL).
- Arithmetic:
  - Comparison is full 16-bit signed; no saturation needed.
  - Ties keep the stored value (results are identical either way).
- Gaps in ivalid do not affect window or frame alignment.

Test Plan:
- Reset then idle: rst=0→1, ivalid pulses with no start → odata=0, ovalid and frame_done never assert, busy=0.
- Basic frame (LEN=8, POOL=2): start, back-to-back inputs 3,7,5,1,0,0,9,9 → ovalid pulses with odata 7,5,0,9, each one cycle after the 2nd, 4th, 6th and 8th ivalid; frame_done coincides with the 4th ovalid; busy falls the same cycle.
- Signed values and gaps (LEN=4, POOL=2): inputs -5,-2 then 3 idle cycles, then -1,-8 → odata -2 then -1; window alignment is unaffected by the gap.
- Partial tail (LEN=5, POOL=2): inputs 1,2,3,4,6 → two outputs, 2 then 4; 6 is dropped; frame_done one cycle after the 5th ivalid, with no ovalid in that cycle.
- Start and reset robustness:
  - start asserted mid-RUN → ignored, counts unchanged.
  - rst asserted after 3 samples → outputs return to 0 immediately.
  - New start then frame 8,8,2,4 (LEN=4) → outputs 8 then 4; no carry-over from the aborted frame.
